// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA control path: AXI response codes,
// BRAM window width and the bridge FSM state encoding.
`timescale 1ns/1ps
package dma_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BRAM_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    WR_RESP  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    RD_RESP  = 3'd6
  } state_e;

endpackage

// File: rtl/axil_bram_master.sv
// AXI4-Lite slave bridging host register accesses onto a single-port
// BRAM-style register file. One access in flight; honours the register
// file's fixed read latency and minimum spacing between enable pulses.
`timescale 1ns/1ps
module axil_bram_master
  import dma_ctrl_pkg::*;
#(
  parameter int S_ADDR_W   = 32,
  parameter int RD_LATENCY = 2,
  parameter int MIN_GAP    = 2
) (
  input  logic                   user_clk,
  input  logic                   user_aresetn,
  input  logic [S_ADDR_W-1:0]    s_axil_awaddr,
  input  logic                   s_axil_awvalid,
  output logic                   s_axil_awready,
  input  logic [31:0]            s_axil_wdata,
  input  logic [3:0]             s_axil_wstrb,
  input  logic                   s_axil_wvalid,
  output logic                   s_axil_wready,
  output logic [1:0]             s_axil_bresp,
  output logic                   s_axil_bvalid,
  input  logic                   s_axil_bready,
  input  logic [S_ADDR_W-1:0]    s_axil_araddr,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  output logic [31:0]            s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  output logic                   bram_en_a,
  output logic [3:0]             bram_we_a,
  output logic [BRAM_ADDR_W-1:0] bram_addr_a,
  output logic [31:0]            bram_wrdata_a,
  input  logic [31:0]            bram_rddata_a
);

  localparam int MAX_CNT = (RD_LATENCY > MIN_GAP) ? RD_LATENCY : MIN_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Gap counter reaches zero on the cycle a new handshake may be taken so
  // that the following enable lands exactly MIN_GAP cycles after the last.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP - 1);
  // RD_WAIT lasts RD_LATENCY cycles; capture happens when the count hits zero.
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LATENCY - 1);
  // Extra write wait cycles beyond the one-cycle issue state.
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'((MIN_GAP > 2) ? (MIN_GAP - 2) : 0);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic                   last_was_rd_q, last_was_rd_d;
  logic                   en_q, en_d;
  logic [3:0]             we_q, we_d;
  logic [BRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wrdata_q, wrdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   bvalid_q, bvalid_d;
  logic                   rvalid_q, rvalid_d;
  logic                   awready_s, arready_s;
  logic                   can_issue_s, wr_elig_s, rd_elig_s;
  logic                   aw_oor_s, ar_oor_s;

  assign aw_oor_s    = (s_axil_awaddr >> BRAM_ADDR_W) != {S_ADDR_W{1'b0}};
  assign ar_oor_s    = (s_axil_araddr >> BRAM_ADDR_W) != {S_ADDR_W{1'b0}};
  assign can_issue_s = user_aresetn && (gap_q == CNT_ZERO);
  assign wr_elig_s   = s_axil_awvalid && s_axil_wvalid;
  assign rd_elig_s   = s_axil_arvalid;

  // Next-state, arbitration and BRAM/response register updates.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = (gap_q != CNT_ZERO) ? (gap_q - CNT_ONE) : gap_q;
    last_was_rd_d = last_was_rd_q;
    en_d          = 1'b0;
    we_d          = 4'h0;
    addr_d        = addr_q;
    wrdata_d      = wrdata_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    bresp_d       = bresp_q;
    awready_s     = 1'b0;
    arready_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_q == IDLE && can_issue_s && wr_elig_s && (!rd_elig_s || last_was_rd_q)) begin
          awready_s     = 1'b1;
          last_was_rd_d = 1'b0;
          if (aw_oor_s) begin
            bresp_d = RESP_SLVERR;
            state_d = WR_RESP;
          end else if (s_axil_wstrb == 4'h0) begin
            bresp_d = RESP_OKAY;
            state_d = WR_RESP;
          end else begin
            bresp_d  = RESP_OKAY;
            state_d  = WR_ISSUE;
            en_d     = 1'b1;
            we_d     = s_axil_wstrb;
            addr_d   = {s_axil_awaddr[BRAM_ADDR_W-1:2], 2'b00};
            wrdata_d = s_axil_wdata;
            gap_d    = GAP_LOAD;
          end
        end else if (can_issue_s && rd_elig_s) begin
          arready_s     = 1'b1;
          last_was_rd_d = 1'b1;
          if (ar_oor_s) begin
            rdata_d = 32'h0000_0000;
            rresp_d = RESP_SLVERR;
            state_d = RD_RESP;
          end else begin
            rresp_d = RESP_OKAY;
            state_d = RD_ISSUE;
            en_d    = 1'b1;
            addr_d  = {s_axil_araddr[BRAM_ADDR_W-1:2], 2'b00};
            gap_d   = GAP_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ISSUE: begin
        if (WR_LOAD == CNT_ZERO) begin
          state_d = WR_RESP;
        end else begin
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = WR_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          state_d = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_ISSUE: begin
        cnt_d   = RD_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          rdata_d = bram_rddata_a;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RD_RESP: begin
        if (s_axil_rready) begin
          state_d = IDLE;
        end else begin
          state_d = RD_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    bvalid_d = (state_d == WR_RESP);
    rvalid_d = (state_d == RD_RESP);
  end

  // State, counters and all registered outputs; synchronous active-low reset.
  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      gap_q         <= CNT_ZERO;
      last_was_rd_q <= 1'b1;
      en_q          <= 1'b0;
      we_q          <= 4'h0;
      addr_q        <= {BRAM_ADDR_W{1'b0}};
      wrdata_q      <= 32'h0000_0000;
      rdata_q       <= 32'h0000_0000;
      rresp_q       <= 2'b00;
      bresp_q       <= 2'b00;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      last_was_rd_q <= last_was_rd_d;
      en_q          <= en_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wrdata_q      <= wrdata_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      bresp_q       <= bresp_d;
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign s_axil_awready = awready_s;
  assign s_axil_wready  = awready_s;
  assign s_axil_arready = arready_s;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign bram_en_a      = en_q;
  assign bram_we_a      = we_q;
  assign bram_addr_a    = addr_q;
  assign bram_wrdata_a  = wrdata_q;

endmodule

// File: tb/tb_axil_bram_master.sv
// Directed bench for axil_bram_master with a latency-exact BRAM model.
`timescale 1ns/1ps
module tb_axil_bram_master;
  import dma_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [11:0] bram_addr;
  logic [31:0] bram_wrdata, bram_rddata;

  always #5 clk = ~clk;

  axil_bram_master #(.S_ADDR_W(32), .RD_LATENCY(2), .MIN_GAP(2)) dut (
    .user_clk(clk), .user_aresetn(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .bram_en_a(bram_en), .bram_we_a(bram_we), .bram_addr_a(bram_addr),
    .bram_wrdata_a(bram_wrdata), .bram_rddata_a(bram_rddata)
  );

  // BRAM model: data valid exactly two cycles after the read enable, junk otherwise.
  logic [31:0] mem [0:1023];
  logic [31:0] pipe1, pipe2;
  assign bram_rddata = pipe2;
  always @(posedge clk) begin
    pipe1 <= (bram_en && bram_we == 4'h0) ? mem[bram_addr[11:2]] : 32'hBAD0_BAD0;
    pipe2 <= pipe1;
    if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr[11:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: enable pulses, spacing, grants and completed read data.
  int          en_cnt = 0, gap_viol = 0, we_viol = 0, last_en_cyc = -100;
  logic [11:0] en_addr;
  logic [3:0]  en_we;
  logic [31:0] en_wdata, rsp_rdata;
  byte         g_kind[$];
  int          g_cyc[$];
  always @(negedge clk) begin
    if (bram_en) begin
      en_cnt++;
      if (cyc - last_en_cyc < 2) gap_viol++;
      last_en_cyc = cyc;
      en_addr = bram_addr; en_we = bram_we; en_wdata = bram_wrdata;
    end
    if (!bram_en && bram_we != 4'h0) we_viol++;
    if (awvalid && awready && wvalid && wready) begin g_kind.push_back(8'd87); g_cyc.push_back(cyc); end
    if (arvalid && arready) begin g_kind.push_back(8'd82); g_cyc.push_back(cyc); end
    if (rvalid && rready) rsp_rdata = rdata;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the address handshake; returns its cycle.
  task automatic wait_accept(input bit is_rd, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (is_rd ? arready : (awready && wready)) begin ok = 1'b1; t = cyc; end
    end
  endtask

  // Wait (bounded) for the response valid; returns its cycle.
  task automatic wait_resp(input bit is_rd, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (is_rd ? rvalid : bvalid) begin ok = 1'b1; t = cyc; end
    end
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_en;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int t0, t1, en0;
    bit ok0, ok1;
    string tag;
    tag = $sformatf("v%0d", idx);
    en0 = en_cnt;
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    if (v.is_rd) begin
      araddr = v.addr; arvalid = 1'b1;
    end else begin
      awaddr = v.addr; wdata = v.data; wstrb = v.strb; awvalid = 1'b1; wvalid = 1'b1;
    end
    wait_accept(v.is_rd, t0, ok0);
    check({tag, " accept"}, 32'(ok0), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_resp(v.is_rd, t1, ok1);
    check({tag, " resp seen"}, 32'(ok1), 32'd1);
    check({tag, " latency"}, 32'(t1 - t0), 32'(v.exp_lat));
    check({tag, " resp"}, 32'(v.is_rd ? rresp : bresp), 32'(v.exp_resp));
    check({tag, " en pulses"}, 32'(en_cnt - en0), 32'(v.exp_en));
    if (v.is_rd) check({tag, " rdata"}, rdata, v.exp_rdata);
    if (!v.is_rd && v.exp_en == 1) begin
      check({tag, " bram addr"}, 32'(en_addr), {20'h0, v.addr[11:2], 2'b00});
      check({tag, " bram we"}, 32'(en_we), 32'(v.strb));
      check({tag, " bram wrdata"}, en_wdata, v.data);
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  int   t, gb, viol;
  bit   ok;
  byte  kind;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    rst_n = 1'b0; bready = 1'b1; rready = 1'b1;
    awaddr = 32'h80; wdata = 32'h1111_1111; wstrb = 4'hF; araddr = 32'h80;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;

    // Reset values, with all request valids asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst ready/valid/en/we", 32'({awready, wready, arready, bvalid, rvalid, bram_en, bram_we}), 32'd0);
    check("rst bram addr", 32'(bram_addr), 32'd0);
    check("rst bram wrdata", bram_wrdata, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst resp", 32'({bresp, rresp}), 32'd0);

    // Round robin with AW/W and AR held together: W first after reset.
    gb = g_kind.size();
    rst_n = 1'b1;
    for (int i = 0; i < 60 && (g_kind.size() - gb) < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rr grant count", 32'(g_kind.size() - gb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      kind = (gb + i < g_kind.size()) ? g_kind[gb + i] : 8'd0;
      check($sformatf("rr grant %0d", i), 32'(kind), (i % 2 == 0) ? 32'd87 : 32'd82);
    end
    if (g_cyc.size() >= gb + 4) begin
      check("rr W->R spacing", 32'(g_cyc[gb + 1] - g_cyc[gb]), 32'd3);
      check("rr R->W spacing", 32'(g_cyc[gb + 2] - g_cyc[gb + 1]), 32'd5);
      check("rr W->R spacing 2", 32'(g_cyc[gb + 3] - g_cyc[gb + 2]), 32'd3);
    end
    check("rr read data", rsp_rdata, 32'h1111_1111);

    // Single-transaction vectors.
    vecs.push_back('{1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_OKAY, 1, 2});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, 1, 4});
    vecs.push_back('{1'b0, 32'h0000_0044, 32'h1234_5678, 4'h3, 32'h0, RESP_OKAY, 1, 2});
    vecs.push_back('{1'b0, 32'h0000_0046, 32'hAABB_CCDD, 4'h8, 32'h0, RESP_OKAY, 1, 2});
    vecs.push_back('{1'b1, 32'h0000_0044, 32'h0, 4'h0, 32'hAA00_5678, RESP_OKAY, 1, 4});
    vecs.push_back('{1'b1, 32'h0001_0000, 32'h0, 4'h0, 32'h0000_0000, RESP_SLVERR, 0, 1});
    vecs.push_back('{1'b0, 32'h0000_0048, 32'hFFFF_FFFF, 4'h0, 32'h0, RESP_OKAY, 0, 1});
    vecs.push_back('{1'b1, 32'h0000_0048, 32'h0, 4'h0, 32'h0000_0000, RESP_OKAY, 1, 4});
    vecs.push_back('{1'b0, 32'h0000_1040, 32'h5555_5555, 4'hF, 32'h0, RESP_SLVERR, 0, 1});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, 1, 4});
    vecs.push_back('{1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, RESP_OKAY, 1, 2});
    vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_OKAY, 1, 4});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0000, RESP_OKAY, 1, 4});
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Write response back-pressure: bvalid/bresp hold, nothing new accepted.
    @(posedge clk); #1;
    bready = 1'b0;
    awaddr = 32'h100; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_accept(1'b0, t, ok);
    check("bp wr accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awaddr = 32'h104; araddr = 32'h100; arvalid = 1'b1;
    wait_resp(1'b0, t, ok);
    check("bp bvalid seen", 32'(ok), 32'd1);
    gb = g_kind.size(); viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== RESP_OKAY || awready || wready || arready) viol++;
    end
    check("bp wr hold", 32'(viol), 32'd0);
    check("bp wr no accept", 32'(g_kind.size() - gb), 32'd0);
    @(posedge clk); #1;
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    check("bp bvalid drop", 32'(bvalid), 32'd0);

    // Read response back-pressure.
    rready = 1'b0;
    araddr = 32'h100; arvalid = 1'b1;
    wait_accept(1'b1, t, ok);
    check("bp rd accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; awaddr = 32'h104; awvalid = 1'b1; wvalid = 1'b1;
    wait_resp(1'b1, t, ok);
    check("bp rvalid seen", 32'(ok), 32'd1);
    gb = g_kind.size(); viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== 32'h5A5A_5A5A || rresp !== RESP_OKAY || awready || arready) viol++;
    end
    check("bp rd hold", 32'(viol), 32'd0);
    check("bp rd no accept", 32'(g_kind.size() - gb), 32'd0);
    @(posedge clk); #1;
    rready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;

    // Reset in RD_WAIT: everything back to reset values, response dropped.
    araddr = 32'h40; arvalid = 1'b1;
    wait_accept(1'b1, t, ok);
    check("rstw accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw ready/valid/en/we", 32'({awready, wready, arready, bvalid, rvalid, bram_en, bram_we}), 32'd0);
    check("rstw bram addr", 32'(bram_addr), 32'd0);
    check("rstw bram wrdata", bram_wrdata, 32'd0);
    check("rstw rdata/resp", rdata | 32'({bresp, rresp}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    viol = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid) viol++;
    end
    check("rstw no rvalid", 32'(viol), 32'd0);
    run_vec('{1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, 1, 4}, 99);

    check("en spacing violations", 32'(gap_viol), 32'd0);
    check("we without en", 32'(we_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
